// File: rtl/ntps_phy_regs_pkg.sv
// Shared offsets, response codes and address decode for the PHY register bank.
package ntps_phy_regs_pkg;

  localparam logic [7:0] ADDR_ID          = 8'h00;
  localparam logic [7:0] ADDR_SCRATCH     = 8'h04;
  localparam logic [7:0] ADDR_NPATHS      = 8'h08;
  localparam logic [7:0] ADDR_CFG_BASE    = 8'h20;
  localparam logic [7:0] ADDR_STAT_BASE   = 8'h40;
  localparam logic [7:0] ADDR_STICKY_BASE = 8'h60;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STATUS_W = 5;

  typedef enum logic [2:0] {
    REG_ID,
    REG_SCRATCH,
    REG_NPATHS,
    REG_CFG,
    REG_STAT,
    REG_STICKY,
    REG_NONE
  } reg_kind_e;

  // Classify a word-aligned byte offset; per-path slots beyond num_paths are unmapped.
  function automatic reg_kind_e decode_reg(input logic [7:0] off, input int num_paths);
    reg_kind_e kind;
    logic      path_ok;
    path_ok = (int'(off[4:2]) < num_paths);
    kind    = REG_NONE;
    if (off == ADDR_ID)
      kind = REG_ID;
    else if (off == ADDR_SCRATCH)
      kind = REG_SCRATCH;
    else if (off == ADDR_NPATHS)
      kind = REG_NPATHS;
    else if (path_ok && off[7:5] == ADDR_CFG_BASE[7:5])
      kind = REG_CFG;
    else if (path_ok && off[7:5] == ADDR_STAT_BASE[7:5])
      kind = REG_STAT;
    else if (path_ok && off[7:5] == ADDR_STICKY_BASE[7:5])
      kind = REG_STICKY;
    return kind;
  endfunction

  // Merge new_val into old_val one byte lane at a time.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/ntps_sync2.sv
// Two-flop synchronizer bringing asynchronous PHY status into the AXI clock domain.
module ntps_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ntps_phy_axil_regs.sv
// AXI-Lite register bank exposing PHY config words, live status and sticky status changes.
module ntps_phy_axil_regs
  import ntps_phy_regs_pkg::*;
#(
  parameter int          NUM_PATHS    = 4,
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] CONFIG_RESET = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE     = 32'h5048_5931
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]         s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [31:0]                   s_axil_wdata,
  input  logic [3:0]                    s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]         s_axil_araddr,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [31:0]                   s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready,
  output logic [32*NUM_PATHS-1:0]       gen_config,
  input  logic [STATUS_W*NUM_PATHS-1:0] xphy_status
);

  localparam int SW = STATUS_W * NUM_PATHS;

  logic                    aw_held;
  logic                    w_held;
  logic [5:0]              aw_word_q;
  logic [31:0]             w_data_q;
  logic [3:0]              w_strb_q;
  logic [32*NUM_PATHS-1:0] cfg_q;
  logic [31:0]             scratch_q;
  logic [SW-1:0]           stat_sync;
  logic [SW-1:0]           stat_prev;
  logic [SW-1:0]           sticky_q;
  logic [SW-1:0]           sticky_clr;
  logic [SW-1:0]           sticky_set;
  reg_kind_e               wr_kind;
  reg_kind_e               rd_kind;
  logic [2:0]              wr_idx;
  logic [2:0]              rd_idx;
  logic                    wr_commit;
  logic [31:0]             rd_data;
  logic [1:0]              rd_resp;
  logic [31:0]             sel_cfg;
  logic [STATUS_W-1:0]     sel_stat;
  logic [STATUS_W-1:0]     sel_sticky;
  logic                    unused_addr_bits;

  assign wr_kind    = decode_reg({aw_word_q, 2'b00}, NUM_PATHS);
  assign wr_idx     = aw_word_q[2:0];
  assign rd_kind    = decode_reg({s_axil_araddr[7:2], 2'b00}, NUM_PATHS);
  assign rd_idx     = s_axil_araddr[4:2];
  assign wr_commit  = aw_held && w_held && !s_axil_bvalid;
  assign sticky_set = stat_sync ^ stat_prev;

  assign s_axil_awready = !aw_held;
  assign s_axil_wready  = !w_held;
  assign s_axil_arready = !s_axil_rvalid;
  assign gen_config     = cfg_q;

  assign unused_addr_bits = ^{s_axil_awaddr[ADDR_WIDTH-1:8], s_axil_awaddr[1:0],
                              s_axil_araddr[ADDR_WIDTH-1:8], s_axil_araddr[1:0]};

  ntps_sync2 #(.WIDTH(SW)) u_status_sync (
    .clock   (axi_aclk),
    .reset_n (axi_aresetn),
    .d       (xphy_status),
    .q       (stat_sync)
  );

  // Hold AW and W independently; commit when both are present, retire on the B handshake.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_word_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
    end else begin
      if (s_axil_awvalid && !aw_held) begin
        aw_held   <= 1'b1;
        aw_word_q <= s_axil_awaddr[7:2];
      end
      if (s_axil_wvalid && !w_held) begin
        w_held   <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end
      if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
        aw_held       <= 1'b0;
        w_held        <= 1'b0;
      end else if (wr_commit) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= (wr_kind inside {REG_CFG, REG_SCRATCH, REG_STICKY}) ? RESP_OKAY
                                                                            : RESP_SLVERR;
      end
    end
  end

  // Byte-gated writes into the config words and scratch register.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      cfg_q     <= {NUM_PATHS{CONFIG_RESET}};
      scratch_q <= '0;
    end else if (wr_commit) begin
      if (wr_kind == REG_SCRATCH)
        scratch_q <= apply_strb(scratch_q, w_data_q, w_strb_q);
      for (int i = 0; i < NUM_PATHS; i++)
        if (wr_kind == REG_CFG && wr_idx == 3'(i))
          cfg_q[i*32 +: 32] <= apply_strb(cfg_q[i*32 +: 32], w_data_q, w_strb_q);
    end
  end

  // Sticky bits all live in byte lane 0, so a W1C only clears when that lane is enabled.
  always_comb begin
    sticky_clr = '0;
    if (wr_commit && wr_kind == REG_STICKY && w_strb_q[0])
      for (int i = 0; i < NUM_PATHS; i++)
        if (wr_idx == 3'(i))
          sticky_clr[i*STATUS_W +: STATUS_W] = w_data_q[STATUS_W-1:0];
  end

  // Latch any change of the synced status; a fresh change beats a same-cycle clear.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      stat_prev <= '0;
      sticky_q  <= '0;
    end else begin
      stat_prev <= stat_sync;
      sticky_q  <= (sticky_q & ~sticky_clr) | sticky_set;
    end
  end

  // Read data is taken from current state, before any write committing this cycle.
  always_comb begin
    sel_cfg    = '0;
    sel_stat   = '0;
    sel_sticky = '0;
    for (int i = 0; i < NUM_PATHS; i++)
      if (rd_idx == 3'(i)) begin
        sel_cfg    = cfg_q[i*32 +: 32];
        sel_stat   = stat_sync[i*STATUS_W +: STATUS_W];
        sel_sticky = sticky_q[i*STATUS_W +: STATUS_W];
      end
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_kind)
      REG_ID:      rd_data = ID_VALUE;
      REG_SCRATCH: rd_data = scratch_q;
      REG_NPATHS:  rd_data = 32'(NUM_PATHS);
      REG_CFG:     rd_data = sel_cfg;
      REG_STAT:    rd_data = 32'(sel_stat);
      REG_STICKY:  rd_data = 32'(sel_sticky);
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  // Accept AR only when no read data is pending, and hold R until it is taken.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= RESP_OKAY;
    end else if (s_axil_arvalid && s_axil_arready) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_data;
      s_axil_rresp  <= rd_resp;
    end else if (s_axil_rvalid && s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ntps_phy_axil_regs.sv
// Self-checking bench for the PHY AXI-Lite register bank.
module tb_ntps_phy_axil_regs;

  localparam int          NP     = 4;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [31:0] ID     = 32'h5048_5931;
  localparam int          LIMIT  = 20;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [31:0]   awaddr;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [31:0]   araddr;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [32*NP-1:0] gen_config;
  logic [5*NP-1:0]  xphy;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference state kept at the level of the register map.
  logic [31:0] m_cfg    [NP];
  logic [31:0] m_scratch;
  logic [4:0]  m_sticky [NP];

  typedef struct {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ntps_phy_axil_regs #(.NUM_PATHS(NP)) dut (
    .axi_aclk       (clk),
    .axi_aresetn    (aresetn),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .gen_config     (gen_config),
    .xphy_status    (xphy)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic note_timeout(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: no handshake within %0d cycles", name, LIMIT);
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_cfg[p]    = 32'h0;
      m_sticky[p] = 5'h0;
    end
    m_scratch = 32'h0;
  endtask

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] d,
                                             input logic [3:0] s);
    int off;
    int p;
    off = int'(addr & 32'hFC);
    if (off == 'h04) begin
      m_scratch = merge_bytes(m_scratch, d, s);
      return OKAY;
    end
    if (off >= 'h20 && off < 'h20 + 4*NP) begin
      p = (off - 'h20) / 4;
      m_cfg[p] = merge_bytes(m_cfg[p], d, s);
      return OKAY;
    end
    if (off >= 'h60 && off < 'h60 + 4*NP) begin
      p = (off - 'h60) / 4;
      if (s[0]) m_sticky[p] = m_sticky[p] & ~d[4:0];
      return OKAY;
    end
    return SLVERR;
  endfunction

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int off;
    int p;
    off = int'(addr & 32'hFC);
    d = 32'h0;
    r = OKAY;
    if (off == 'h00)
      d = ID;
    else if (off == 'h04)
      d = m_scratch;
    else if (off == 'h08)
      d = NP;
    else if (off >= 'h20 && off < 'h20 + 4*NP) begin
      p = (off - 'h20) / 4;
      d = m_cfg[p];
    end else if (off >= 'h40 && off < 'h40 + 4*NP) begin
      p = (off - 'h40) / 4;
      d = {27'h0, xphy[p*5 +: 5]};
    end else if (off >= 'h60 && off < 'h60 + 4*NP) begin
      p = (off - 'h60) / 4;
      d = {27'h0, m_sticky[p]};
    end else
      r = SLVERR;
  endtask

  // Drive new PHY status and record which bits will latch as sticky once synced.
  task automatic drive_status(input logic [5*NP-1:0] new_status);
    for (int p = 0; p < NP; p++)
      m_sticky[p] = m_sticky[p] | (xphy[p*5 +: 5] ^ new_status[p*5 +: 5]);
    xphy = new_status;
  endtask

  // Full write transaction; starts and ends on a falling edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    int   cyc;
    logic aw_fire;
    logic w_fire;
    awaddr = addr; awvalid = 1'b1;
    wdata  = data; wstrb   = strb; wvalid = 1'b1;
    bready = 1'b1;
    cyc = 0;
    while ((awvalid || wvalid) && cyc < LIMIT) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); @(negedge clk); cyc++;
      if (aw_fire) awvalid = 1'b0;
      if (w_fire)  wvalid  = 1'b0;
    end
    while (!bvalid && cyc < LIMIT) begin
      @(negedge clk); cyc++;
    end
    if (!bvalid) begin
      awvalid = 1'b0; wvalid = 1'b0;
      note_timeout("write_handshake");
      resp = 2'b11;
    end else begin
      resp = bresp;
      @(posedge clk); @(negedge clk);
    end
  endtask

  // Full read transaction; starts and ends on a falling edge.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int   cyc;
    logic fire;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    cyc = 0;
    while (arvalid && cyc < LIMIT) begin
      fire = arready;
      @(posedge clk); @(negedge clk); cyc++;
      if (fire) arvalid = 1'b0;
    end
    while (!rvalid && cyc < LIMIT) begin
      @(negedge clk); cyc++;
    end
    if (!rvalid) begin
      arvalid = 1'b0;
      note_timeout("read_handshake");
      data = 32'hDEAD_DEAD;
      resp = 2'b11;
    end else begin
      data = rdata;
      resp = rresp;
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic check_gen_config(input string tag);
    for (int p = 0; p < NP; p++)
      check_output($sformatf("%s_cfg%0d", tag, p), gen_config[p*32 +: 32], m_cfg[p]);
  endtask

  task automatic read_vs_model(input logic [31:0] addr, input string tag);
    logic [31:0] got_d, exp_d;
    logic [1:0]  got_r, exp_r;
    axi_read(addr, got_d, got_r);
    model_read(addr, exp_d, exp_r);
    check_output($sformatf("%s_rresp", tag), 32'(got_r), 32'(exp_r));
    check_output($sformatf("%s_rdata", tag), got_d, exp_d);
  endtask

  task automatic write_vs_model(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                                input string tag);
    logic [1:0] got_r, exp_r;
    axi_write(addr, d, s, got_r);
    exp_r = model_write(addr, d, s);
    check_output($sformatf("%s_bresp", tag), 32'(got_r), 32'(exp_r));
    check_gen_config(tag);
  endtask

  // Apply one table vector and compare against its recorded expectation.
  task automatic apply_stimulus(input vec_t v, input int idx);
    logic [31:0] got_d;
    logic [1:0]  got_r, unused_r;
    if (v.is_write) begin
      axi_write(v.addr, v.wdata, v.strb, got_r);
      unused_r = model_write(v.addr, v.wdata, v.strb);
      check_output($sformatf("vec%0d_bresp", idx), 32'(got_r), 32'(v.exp_resp));
      check_gen_config($sformatf("vec%0d", idx));
    end else begin
      axi_read(v.addr, got_d, got_r);
      check_output($sformatf("vec%0d_rresp", idx), 32'(got_r), 32'(v.exp_resp));
      check_output($sformatf("vec%0d_rdata", idx), got_d, v.exp_rdata);
    end
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  slot;
    logic [1:0]  resp;

    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    xphy = '0;
    model_reset();

    vecs.push_back('{1'b0, 32'h00, 32'h0,         4'h0,    OKAY,   ID});
    vecs.push_back('{1'b0, 32'h08, 32'h0,         4'h0,    OKAY,   32'd4});
    vecs.push_back('{1'b1, 32'h24, 32'hA5A5_1234, 4'b0011, OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h24, 32'h0,         4'h0,    OKAY,   32'h0000_1234});
    vecs.push_back('{1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF,    SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 32'h0,         4'h0,    OKAY,   ID});
    vecs.push_back('{1'b0, 32'h84, 32'h0,         4'h0,    SLVERR, 32'h0});
    vecs.push_back('{1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF,    OKAY,   32'h0});
    vecs.push_back('{1'b1, 32'h04, 32'h0000_0000, 4'b0100, OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h04, 32'h0,         4'h0,    OKAY,   32'hDE00_BEEF});
    vecs.push_back('{1'b1, 32'h2C, 32'hFFFF_FFFF, 4'hF,    OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h2C, 32'h0,         4'h0,    OKAY,   32'hFFFF_FFFF});
    vecs.push_back('{1'b1, 32'h30, 32'h1111_1111, 4'hF,    SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h30, 32'h0,         4'h0,    SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h1C, 32'h0,         4'h0,    SLVERR, 32'h0});
    vecs.push_back('{1'b1, 32'h44, 32'hFFFF_FFFF, 4'hF,    SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h40, 32'h0,         4'h0,    OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h60, 32'h0,         4'h0,    OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'hFC, 32'h0,         4'h0,    SLVERR, 32'h0});
    vecs.push_back('{1'b1, 32'h20, 32'h1234_5678, 4'b1000, OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h20, 32'h0,         4'h0,    OKAY,   32'h1200_0000});
    vecs.push_back('{1'b0, 32'hABCD_0126, 32'h0,  4'h0,    OKAY,   32'h0000_1234});

    // Reset state.
    repeat (3) @(negedge clk);
    check_output("rst_awready", 32'(awready), 32'd1);
    check_output("rst_wready",  32'(wready),  32'd1);
    check_output("rst_arready", 32'(arready), 32'd1);
    check_output("rst_bvalid",  32'(bvalid),  32'd0);
    check_output("rst_rvalid",  32'(rvalid),  32'd0);
    check_output("rst_bresp",   32'(bresp),   32'd0);
    check_output("rst_rresp",   32'(rresp),   32'd0);
    check_output("rst_rdata",   rdata,        32'd0);
    check_gen_config("rst");
    aresetn = 1'b1;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i], i);
    check_output("path1_cfg_after_table", gen_config[63:32], 32'h0000_1234);

    // Status toggle on path 1, sticky capture and W1C.
    drive_status(xphy | 20'h000E0);
    repeat (3) @(negedge clk);
    read_vs_model(32'h44, "stat1");
    read_vs_model(32'h64, "sticky1_set");
    read_vs_model(32'h60, "sticky0_quiet");
    write_vs_model(32'h64, 32'h1F, 4'b0001, "sticky1_w1c");
    read_vs_model(32'h64, "sticky1_cleared");

    // W1C commits on the same edge a new status change sets the bit.
    drive_status(xphy & ~20'h00020);
    @(posedge clk); @(negedge clk);
    awaddr = 32'h64; wdata = 32'h1; wstrb = 4'b0001; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    check_output("setwins_bvalid", 32'(bvalid), 32'd1);
    check_output("setwins_bresp",  32'(bresp),  32'(OKAY));
    @(posedge clk); @(negedge clk);
    resp = model_write(32'h64, 32'h1, 4'b0001);
    m_sticky[1] = m_sticky[1] | 5'b00001;
    read_vs_model(32'h64, "setwins_sticky");

    // W early, AW late, B held off for four cycles.
    bready = 1'b0;
    wdata = 32'h1357_9BDF; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0;
    check_output("early_w_wready", 32'(wready), 32'd0);
    repeat (4) @(negedge clk);
    check_output("early_w_no_b", 32'(bvalid), 32'd0);
    awaddr = 32'h28; awvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    check_output("late_aw_awready", 32'(awready), 32'd0);
    @(posedge clk); @(negedge clk);
    resp = model_write(32'h28, 32'h1357_9BDF, 4'hF);
    check_output("late_aw_bresp", 32'(bresp), 32'(OKAY));
    check_gen_config("late_aw");
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("bhold%0d_bvalid", k),  32'(bvalid),  32'd1);
      check_output($sformatf("bhold%0d_awready", k), 32'(awready), 32'd0);
      if (k < 3) @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_output("post_b_bvalid",  32'(bvalid),  32'd0);
    check_output("post_b_awready", 32'(awready), 32'd1);
    check_output("post_b_wready",  32'(wready),  32'd1);
    repeat (3) @(negedge clk);
    check_output("single_commit_bvalid", 32'(bvalid), 32'd0);
    read_vs_model(32'h28, "late_aw_readback");

    // Randomized traffic against the reference model.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive_status(20'($urandom));
        repeat (4) @(negedge clk);
      end
      slot = 6'($urandom_range(0, 39));
      addr = $urandom;
      addr[7:0] = {slot, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        write_vs_model(addr, data, 4'($urandom), $sformatf("rnd%0d_wr", k));
      end else
        read_vs_model(addr, $sformatf("rnd%0d_rd", k));
    end

    // Reset in the middle of a pending write.
    drive_status('0);
    repeat (4) @(negedge clk);
    awaddr = 32'h04; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; aresetn = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    aresetn = 1'b1;
    model_reset();
    check_output("abort_bvalid",  32'(bvalid),  32'd0);
    check_output("abort_awready", 32'(awready), 32'd1);
    check_output("abort_wready",  32'(wready),  32'd1);
    check_gen_config("abort");
    bready = 1'b1;
    @(negedge clk);
    read_vs_model(32'h04, "abort_scratch");
    read_vs_model(32'h24, "abort_cfg1");
    read_vs_model(32'h64, "abort_sticky1");
    read_vs_model(32'h44, "abort_stat1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
